// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus load/store channel between the CPU (master) and a
// memory-mapped responder (slave).
interface mmio_uart_tx_if #(
  parameter int XLEN = 32
);
  logic            load;
  logic            store;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;

  modport master (
    output load, store, address, store_data,
    input  load_data
  );

  modport slave (
    input  load, store, address, store_data,
    output load_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Stores to TXDATA queue bytes; STATUS and BAUD_DIV let firmware poll and
// configure the line. Frames are sent back to back while the FIFO has data.
module mmio_uart_tx #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] BASE        = 32'h1000_0000,
  parameter int              DEPTH       = 8,
  parameter logic [15:0]     DEFAULT_DIV = 16'd868
) (
  input  logic                 clock,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 tx,
  output logic                 irq_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [15:0]     baudCnt_q, baudCnt_d;
  logic            tx_q, tx_d;
  logic            irq_q;
  logic [15:0]     baudDiv_q, baudDiv_d;
  logic            overflow_q, overflow_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      fifoMem [DEPTH];

  logic            sel;
  logic [1:0]      offset;
  logic            wrEn;
  logic            pushReq;
  logic            pushOk;
  logic            pop;
  logic            fifoEmpty;
  logic            fifoFull;
  logic            bitDone;
  logic [15:0]     baudReload;
  logic [XLEN-1:0] status;
  logic [XLEN-1:0] readMux;
  logic            unusedBits;

  assign sel        = (bus.address[XLEN-1:4] == BASE[XLEN-1:4]);
  assign offset     = bus.address[3:2];
  assign wrEn       = bus.store && sel;
  assign pushReq    = wrEn && (offset == 2'd0);
  assign fifoEmpty  = (count_q == '0);
  assign fifoFull   = (count_q == CW'(DEPTH));
  assign bitDone    = (baudCnt_q == 16'd0);
  assign baudReload = baudDiv_q - 16'd1;
  assign pushOk     = pushReq && (!fifoFull || pop);
  assign unusedBits = ^{bus.address[1:0], bus.store_data[XLEN-1:16]};

  // Transmit FSM: pick the next state, shifter and line level, and decide when to pop
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    baudCnt_d = baudCnt_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) pop = 1'b1;
      end
      START: begin
        if (bitDone) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          baudCnt_d = baudReload;
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bitDone) begin
          baudCnt_d = baudReload;
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitCnt_d = bitCnt_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bitDone) begin
          if (!fifoEmpty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d   = START;
      shift_d   = fifoMem[rdPtr_q];
      tx_d      = 1'b0;
      bitCnt_d  = 3'd0;
      baudCnt_d = baudReload;
    end
  end

  // FIFO bookkeeping and register writes from the bus
  always_comb begin
    wrPtr_d    = pushOk ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d    = count_q + CW'(pushOk) - CW'(pop);
    overflow_d = overflow_q;
    baudDiv_d  = baudDiv_q;
    if (pushReq && !pushOk) begin
      overflow_d = 1'b1;
    end else if (wrEn && (offset == 2'd1) && bus.store_data[3]) begin
      overflow_d = 1'b0;
    end
    if (wrEn && (offset == 2'd2)) begin
      baudDiv_d = (bus.store_data[15:0] == 16'd0) ? 16'd1 : bus.store_data[15:0];
    end
  end

  // Read data path: combinational, shows register values from before the edge
  always_comb begin
    status           = '0;
    status[0]        = (state_q != IDLE);
    status[1]        = fifoEmpty;
    status[2]        = fifoFull;
    status[3]        = overflow_q;
    status[8 +: CW]  = count_q;
    readMux          = '0;
    if (bus.load && sel) begin
      case (offset)
        2'd1:    readMux = status;
        2'd2:    readMux = {{(XLEN-16){1'b0}}, baudDiv_q};
        default: readMux = '0;
      endcase
    end
  end

  assign bus.load_data = readMux;
  assign tx            = tx_q;
  assign irq_empty     = irq_q;

  // State and register update; reset aborts any frame and empties the FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      bitCnt_q   <= 3'd0;
      baudCnt_q  <= 16'd0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
      baudDiv_q  <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      baudCnt_q  <= baudCnt_d;
      tx_q       <= tx_d;
      irq_q      <= fifoEmpty && (state_q == IDLE);
      baudDiv_q  <= baudDiv_d;
      overflow_q <= overflow_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clock) begin
    if (pushOk) fifoMem[wrPtr_q] <= bus.store_data[7:0];
  end

endmodule
